// File: rtl/clk_div_meter_if.sv
// Control and result bundle for clk_div_meter: start request, expected
// period, and the registered measurement results.
interface clk_div_meter_if #(
    parameter int CNT_W = 10
);
    logic             start_i;
    logic [CNT_W-1:0] exp_period_i;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             match_o;
    logic             timeout_o;

    // Requester side: issues start and expected period, observes results.
    modport master (
        output start_i, exp_period_i,
        input  busy_o, done_o, period_o, high_o, match_o, timeout_o
    );

    // Meter side.
    modport slave (
        input  start_i, exp_period_i,
        output busy_o, done_o, period_o, high_o, match_o, timeout_o
    );
endinterface

// File: rtl/clk_div_meter.sv
// Measures one rising-to-rising period and the high time of an asynchronous
// divided clock, in clk_i cycles, with a timeout so a stuck input never hangs.
module clk_div_meter #(
    parameter int CNT_W       = 10,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic            clk_i,
    input  logic            rst_n,
    input  logic            clk_div_i,
    clk_div_meter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_e;

    // Last tcnt value still allowed in ARM/MEAS before aborting.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e           state_q, state_d;
    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d, tcnt_q, tcnt_d;
    logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
    logic             match_q, match_d, timeout_q, timeout_d;
    logic             rise, tmo_hit;

    // Edge detect on the synchronized input; the synchronizer delay is the
    // same for both edges of a period, so it cancels out of the count.
    assign rise    = s2_q & ~s3_q;
    assign tmo_hit = (tcnt_q == TMO_LAST);

    // Next-state, counter and result computation.
    always_comb begin
        state_d   = state_q;
        s1_d      = clk_div_i;
        s2_d      = s1_q;
        s3_d      = s2_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        tcnt_d    = tcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        match_d   = match_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = ARM;
                    tcnt_d  = '0;
                end
            end
            ARM: begin
                // Rise is checked first so it wins over a same-cycle timeout.
                if (rise) begin
                    state_d = MEAS;
                    cnt_d   = CNT_W'(1);
                    hcnt_d  = CNT_W'(1);
                    tcnt_d  = '0;
                end else if (tmo_hit) begin
                    state_d   = DONE;
                    period_d  = '0;
                    high_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
            end
            MEAS: begin
                if (rise) begin
                    state_d   = DONE;
                    period_d  = cnt_q;
                    high_d    = hcnt_q;
                    timeout_d = 1'b0;
                end else if (tmo_hit) begin
                    state_d   = DONE;
                    period_d  = '0;
                    high_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    hcnt_d = hcnt_q + CNT_W'(s2_q);
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // exp_period_i is only looked at in this cycle.
                match_d = (period_q == bus.exp_period_i) & ~timeout_q;
                state_d = IDLE;
            end
        endcase
    end

    // State, synchronizer and result registers with async active-low reset.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            tcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            match_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            tcnt_q    <= tcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            match_q   <= match_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.busy_o    = (state_q != IDLE);
    assign bus.done_o    = (state_q == DONE);
    assign bus.period_o  = period_q;
    assign bus.high_o    = high_q;
    assign bus.match_o   = match_q;
    assign bus.timeout_o = timeout_q;
endmodule

// File: tb/tb_clk_div_meter.sv
// Scoreboard bench for clk_div_meter: expected results are queued at start
// and compared one cycle after each done_o pulse.
module tb_clk_div_meter;
    localparam int W = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic div_a = 1'b0;
    logic div_b = 1'b0;

    always #5 clk = ~clk;

    clk_div_meter_if #(.CNT_W(W)) bus_a ();
    clk_div_meter_if #(.CNT_W(W)) bus_b ();

    clk_div_meter #(.CNT_W(W), .TIMEOUT_CYC(1000)) dut_a (
        .clk_i(clk), .rst_n(rst_n), .clk_div_i(div_a), .bus(bus_a)
    );
    clk_div_meter #(.CNT_W(W), .TIMEOUT_CYC(1023)) dut_b (
        .clk_i(clk), .rst_n(rst_n), .clk_div_i(div_b), .bus(bus_b)
    );

    typedef struct {
        int per;
        int hi;
        int m;
        int to;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t ea, eb, en;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   done_a = 0;
    int   done_b = 0;

    // Pattern state: hi==0 -> stuck low, lo==0 -> stuck high.
    int a_hi = 3, a_lo = 4, a_ph = 0;
    int b_hi = 500, b_lo = 523, b_ph = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Divided-clock generators, stepped on the falling edge of clk.
    initial forever begin
        @(negedge clk);
        if (a_lo == 0) div_a = 1'b1;
        else if (a_hi == 0) div_a = 1'b0;
        else begin
            div_a = (a_ph < a_hi);
            a_ph  = (a_ph + 1) % (a_hi + a_lo);
        end
    end

    initial forever begin
        @(negedge clk);
        div_b = (b_ph < b_hi);
        b_ph  = (b_ph + 1) % (b_hi + b_lo);
    end

    // Result monitors: pop the scoreboard one cycle after done_o.
    initial forever begin
        @(negedge clk);
        if (bus_a.done_o) begin
            done_a++;
            @(negedge clk);
            if (sb_a.size() == 0) chk("a_unexpected_done", 1, 0);
            else begin
                ea = sb_a.pop_front();
                chk("a_period", bus_a.period_o, ea.per);
                chk("a_high", bus_a.high_o, ea.hi);
                chk("a_match", bus_a.match_o, ea.m);
                chk("a_timeout", bus_a.timeout_o, ea.to);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus_b.done_o) begin
            done_b++;
            @(negedge clk);
            if (sb_b.size() == 0) chk("b_unexpected_done", 1, 0);
            else begin
                eb = sb_b.pop_front();
                chk("b_period", bus_b.period_o, eb.per);
                chk("b_high", bus_b.high_o, eb.hi);
                chk("b_match", bus_b.match_o, eb.m);
                chk("b_timeout", bus_b.timeout_o, eb.to);
            end
        end
    end

    // Returns at the posedge just after div_a went 0->1 on the prior negedge.
    task automatic wait_rise_a();
        logic p;
        p = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (div_a && !p) return;
            p = div_a;
        end
        chk("a_rise_wait", 0, 1);
    endtask

    // One measurement on dut_a. lat>0 checks the start-to-done distance,
    // rep>0 re-pulses start that many cycles after the first pulse.
    task automatic run_a(input int ep, input int per, input int hi, input int m,
                         input int to, input int lat, input bit align, input int rep);
        int dc, seen;
        exp_t e;
        e.per = per; e.hi = hi; e.m = m; e.to = to;
        sb_a.push_back(e);
        dc   = done_a;
        seen = 0;
        if (align) wait_rise_a();
        @(negedge clk);
        bus_a.exp_period_i = W'(ep);
        bus_a.start_i      = 1'b1;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            bus_a.start_i = (k == rep);
            if (bus_a.done_o) begin
                seen = k;
                break;
            end
        end
        chk("a_done_seen", (seen != 0), 1);
        if (lat > 0) chk("a_latency", seen, lat);
        repeat (3) @(negedge clk);
        chk("a_busy_after", bus_a.busy_o, 0);
        chk("a_done_count", done_a - dc, 1);
    endtask

    initial begin
        int seen;
        bus_a.start_i = 1'b0; bus_a.exp_period_i = '0;
        bus_b.start_i = 1'b0; bus_b.exp_period_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus_a.busy_o, 0);
        chk("rst_done", bus_a.done_o, 0);
        chk("rst_period", bus_a.period_o, 0);
        chk("rst_timeout", bus_a.timeout_o, 0);
        chk("rst_match", bus_a.match_o, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // High 3 / low 4: matching and mismatching expected period.
        run_a(7, 7, 3, 1, 0, 0, 1'b1, 0);
        run_a(6, 7, 3, 0, 0, 0, 1'b1, 0);
        // start re-pulsed during MEAS is ignored, then a fresh measurement.
        run_a(7, 7, 3, 1, 0, 0, 1'b1, 4);
        run_a(7, 7, 3, 1, 0, 0, 1'b1, 0);

        // Stuck low then stuck high: timeout exactly 1000 cycles after ARM.
        a_hi = 0;
        repeat (6) @(negedge clk);
        run_a(0, 0, 0, 0, 1, 1001, 1'b0, 0);
        a_hi = 1; a_lo = 0;
        repeat (6) @(negedge clk);
        run_a(0, 0, 0, 0, 1, 1001, 1'b0, 0);

        // Fastest pattern: period 2.
        a_hi = 1; a_lo = 1; a_ph = 0;
        repeat (6) @(negedge clk);
        run_a(2, 2, 1, 1, 0, 0, 1'b1, 0);

        // Asynchronous reset in the middle of MEAS.
        a_hi = 3; a_lo = 4; a_ph = 0;
        repeat (10) @(negedge clk);
        wait_rise_a();
        @(negedge clk);
        bus_a.exp_period_i = W'(7);
        bus_a.start_i = 1'b1;
        @(negedge clk);
        bus_a.start_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", bus_a.busy_o, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus_a.busy_o, 0);
        chk("mid_rst_done", bus_a.done_o, 0);
        chk("mid_rst_period", bus_a.period_o, 0);
        chk("mid_rst_high", bus_a.high_o, 0);
        chk("mid_rst_match", bus_a.match_o, 0);
        chk("mid_rst_timeout", bus_a.timeout_o, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run_a(7, 7, 3, 1, 0, 0, 1'b1, 0);

        // Period 1023 with TIMEOUT_CYC 1023: rise wins at the boundary.
        en.per = 1023; en.hi = 500; en.m = 1; en.to = 0;
        sb_b.push_back(en);
        seen = 0;
        @(negedge clk);
        bus_b.exp_period_i = W'(1023);
        bus_b.start_i = 1'b1;
        for (int k = 1; k <= 4000; k++) begin
            @(negedge clk);
            bus_b.start_i = 1'b0;
            if (bus_b.done_o) begin
                seen = k;
                break;
            end
        end
        chk("b_done_seen", (seen != 0), 1);
        repeat (3) @(negedge clk);
        chk("b_done_count", done_b, 1);
        chk("b_busy_after", bus_b.busy_o, 0);
        chk("a_sb_empty", sb_a.size(), 0);
        chk("b_sb_empty", sb_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
